// File: rtl/diagonal_expand.sv
// ============================================================================
// Module   : diagonal_expand
// Brief    : Captures SIZE diagonal elements, then streams the full SIZE x SIZE
//            diagonal matrix row-major with zero off-diagonal entries and
//            out_tlast on the final element.
//            Optional macro DIAG_EXPAND_PINGPONG_EN: two buffer banks so the
//            next matrix loads while the current one is emitted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module diagonal_expand #(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  out_tlast
);

    localparam int            CW     = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(SIZE - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [CW-1:0]         r_k;
    logic [CW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_k_last;
    logic                  w_rc_last;
    logic                  w_emit;
    logic [DATA_WIDTH-1:0] w_rd_elem;

    assign w_in_fire  = in_tvalid && in_tready;
    assign w_out_fire = w_emit && out_tready;
    assign w_k_last   = (r_k == C_LAST);
    assign w_rc_last  = (r_row == C_LAST) && (r_col == C_LAST);

    // Load index: advances per accepted input, wraps after the last diagonal element
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k <= '0;
        end else if (w_in_fire) begin
            r_k <= w_k_last ? '0 : r_k + C_ONE;
        end
    end

    // Emit position: column advances per output transfer, row advances on column wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_out_fire) begin
            if (r_col == C_LAST) begin
                r_col <= '0;
                r_row <= (r_row == C_LAST) ? '0 : r_row + C_ONE;
            end else begin
                r_col <= r_col + C_ONE;
            end
        end
    end

`ifdef DIAG_EXPAND_PINGPONG_EN

    logic [DATA_WIDTH-1:0] r_buf [2][SIZE];
    logic [1:0]            r_full;
    logic                  r_wr_sel;
    logic                  r_rd_sel;

    // Diagonal storage for both banks; contents are don't-care until loaded
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_buf[r_wr_sel][r_k] <= in_tdata;
        end
    end

    // Bank bookkeeping: a completed load marks the write bank full, a completed
    // emission frees the read bank; both can happen on different banks at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full   <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
        end else begin
            if (w_in_fire && w_k_last) begin
                r_full[r_wr_sel] <= 1'b1;
                r_wr_sel         <= ~r_wr_sel;
            end
            if (w_out_fire && w_rc_last) begin
                r_full[r_rd_sel] <= 1'b0;
                r_rd_sel         <= ~r_rd_sel;
            end
        end
    end

    assign in_tready = rst && !r_full[r_wr_sel];
    assign w_emit    = r_full[r_rd_sel];
    assign w_rd_elem = r_buf[r_rd_sel][r_row];

`else

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_buf [SIZE];

    // Diagonal storage; written only while loading so emitted data stays stable
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_buf[r_k] <= in_tdata;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: LOAD until the last diagonal arrives, EMIT until the last element leaves
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (w_in_fire && w_k_last)   w_state_nxt = S_EMIT;
            S_EMIT:  if (w_out_fire && w_rc_last) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Handshake decode from registered state only; ready is held low during reset
    assign in_tready = rst && (r_state == S_LOAD);
    assign w_emit    = (r_state == S_EMIT);
    assign w_rd_elem = r_buf[r_row];

`endif

    assign out_tvalid = w_emit;
    assign out_tdata  = (w_emit && (r_row == r_col)) ? w_rd_elem : '0;
    assign out_tlast  = w_emit && w_rc_last;

endmodule

`default_nettype wire
